// File: rtl/operand_fetch_stage_pkg.sv
// Shared types and constants for the operand fetch stage and its bypass muxes.
// Strand and register-index widths, ALU op width, PC pseudo-register, hazard FSM states.
package operand_fetch_stage_pkg;

    localparam int NUM_STRANDS = 4;
    localparam int STRAND_BITS = $clog2(NUM_STRANDS);
    localparam int REG_BITS    = 5;
    localparam int ALU_OP_W    = 6;
    localparam int PC_REG      = 31;

    typedef logic [STRAND_BITS-1:0] strand_t;
    typedef logic [REG_BITS-1:0]    reg_index_t;
    typedef logic [ALU_OP_W-1:0]    alu_op_t;
    typedef logic [31:0]            word_t;

    typedef enum logic {
        ST_RUN,
        ST_LOAD_WAIT
    } fetch_state_t;

    // A downstream stage supplies a source when it holds a live writer of that register in this strand.
    function automatic logic stage_match(input logic vld, input logic has_dest,
                                         input strand_t stage_strand, input strand_t src_strand,
                                         input reg_index_t dest, input reg_index_t src);
        return vld && has_dest && (stage_strand == src_strand) && (dest == src);
    endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Decode-side instruction bus into the fetch stage and the registered ALU-side bus out of it.
// The stage uses the slave view; decode/execute (or a bench) use the master view.
interface operand_fetch_stage_if;
    import operand_fetch_stage_pkg::*;

    logic       id_valid;
    strand_t    id_strand;
    word_t      id_pc;
    alu_op_t    id_alu_op;
    reg_index_t id_src1_reg;
    reg_index_t id_src2_reg;
    logic       id_src2_is_imm;
    word_t      id_immediate;
    reg_index_t id_dest_reg;
    logic       id_has_dest;
    logic       id_is_load;
    logic       id_stall;

    logic       ds_valid;
    strand_t    ds_strand;
    alu_op_t    ds_alu_op;
    word_t      ds_operand1;
    word_t      ds_operand2;
    reg_index_t ds_dest_reg;
    logic       ds_has_dest;
    logic       ds_is_load;

    modport master (
        output id_valid, id_strand, id_pc, id_alu_op, id_src1_reg, id_src2_reg,
               id_src2_is_imm, id_immediate, id_dest_reg, id_has_dest, id_is_load,
        input  id_stall,
        input  ds_valid, ds_strand, ds_alu_op, ds_operand1, ds_operand2,
               ds_dest_reg, ds_has_dest, ds_is_load
    );

    modport slave (
        input  id_valid, id_strand, id_pc, id_alu_op, id_src1_reg, id_src2_reg,
               id_src2_is_imm, id_immediate, id_dest_reg, id_has_dest, id_is_load,
        output id_stall,
        output ds_valid, ds_strand, ds_alu_op, ds_operand1, ds_operand2,
               ds_dest_reg, ds_has_dest, ds_is_load
    );

endinterface

// File: rtl/operand_fetch_stage_bypass_mux.sv
// Single-source operand priority mux: PC pseudo-register, then ex, ma, wb bypass, then register file.
// Purely combinational; also reports the ex match so the caller can detect load-use hazards.
module operand_bypass_mux
    import operand_fetch_stage_pkg::*;
(
    input  reg_index_t src_reg,
    input  strand_t    id_strand,
    input  word_t      id_pc,
    input  logic       ex_valid,
    input  logic       ex_has_dest,
    input  strand_t    ex_strand,
    input  reg_index_t ex_dest_reg,
    input  word_t      ex_result,
    input  logic       ma_valid,
    input  logic       ma_has_dest,
    input  strand_t    ma_strand,
    input  reg_index_t ma_dest_reg,
    input  word_t      ma_result,
    input  logic       wb_enable,
    input  strand_t    wb_strand,
    input  reg_index_t wb_reg,
    input  word_t      wb_value,
    input  word_t      rf_value,
    output word_t      value,
    output logic       ex_match
);

    logic ma_match;
    logic wb_match;

    always_comb begin
        ex_match = stage_match(ex_valid, ex_has_dest, ex_strand, id_strand, ex_dest_reg, src_reg);
        ma_match = stage_match(ma_valid, ma_has_dest, ma_strand, id_strand, ma_dest_reg, src_reg);
        wb_match = stage_match(wb_enable, 1'b1, wb_strand, id_strand, wb_reg, src_reg);

        value = rf_value;
        if (src_reg == reg_index_t'(PC_REG)) value = id_pc;
        else if (ex_match)                   value = ex_result;
        else if (ma_match)                   value = ma_result;
        else if (wb_match)                   value = wb_value;
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: resolves ALU operands with full bypass, inserts one bubble per load-use hazard.
// Latency 1 cycle id_* -> ds_*; id_stall is combinational (downstream stall or load-use, unless rolled back).
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    operand_fetch_stage_if.slave         fetch,
    input  word_t                        rf_src1_value,
    input  word_t                        rf_src2_value,
    input  logic                         ex_valid,
    input  logic                         ex_has_dest,
    input  logic                         ex_is_load,
    input  strand_t                      ex_strand,
    input  reg_index_t                   ex_dest_reg,
    input  word_t                        ex_result,
    input  logic                         ma_valid,
    input  logic                         ma_has_dest,
    input  strand_t                      ma_strand,
    input  reg_index_t                   ma_dest_reg,
    input  word_t                        ma_result,
    input  logic                         wb_enable,
    input  strand_t                      wb_strand,
    input  reg_index_t                   wb_reg,
    input  word_t                        wb_value,
    input  logic                         rollback_valid,
    input  strand_t                      rollback_strand,
    input  logic                         downstream_stall
);

    fetch_state_t state_q, state_nxt;

    logic  ex_valid_eff;
    logic  ex_match1, ex_match2;
    word_t src1_value, src2_value, operand2;
    logic  use1, use2, load_use, rb_id, rb_ds;

    // In LOAD_WAIT the ex slot holds our own bubble, so the load is resolved from ma.
    assign ex_valid_eff = ex_valid && (state_q == ST_RUN);

    operand_bypass_mux u_src1 (
        .src_reg(fetch.id_src1_reg), .id_strand(fetch.id_strand), .id_pc(fetch.id_pc),
        .ex_valid(ex_valid_eff), .ex_has_dest(ex_has_dest), .ex_strand(ex_strand),
        .ex_dest_reg(ex_dest_reg), .ex_result(ex_result),
        .ma_valid(ma_valid), .ma_has_dest(ma_has_dest), .ma_strand(ma_strand),
        .ma_dest_reg(ma_dest_reg), .ma_result(ma_result),
        .wb_enable(wb_enable), .wb_strand(wb_strand), .wb_reg(wb_reg), .wb_value(wb_value),
        .rf_value(rf_src1_value), .value(src1_value), .ex_match(ex_match1)
    );

    operand_bypass_mux u_src2 (
        .src_reg(fetch.id_src2_reg), .id_strand(fetch.id_strand), .id_pc(fetch.id_pc),
        .ex_valid(ex_valid_eff), .ex_has_dest(ex_has_dest), .ex_strand(ex_strand),
        .ex_dest_reg(ex_dest_reg), .ex_result(ex_result),
        .ma_valid(ma_valid), .ma_has_dest(ma_has_dest), .ma_strand(ma_strand),
        .ma_dest_reg(ma_dest_reg), .ma_result(ma_result),
        .wb_enable(wb_enable), .wb_strand(wb_strand), .wb_reg(wb_reg), .wb_value(wb_value),
        .rf_value(rf_src2_value), .value(src2_value), .ex_match(ex_match2)
    );

    assign operand2 = fetch.id_src2_is_imm ? fetch.id_immediate : src2_value;

    // The PC pseudo-register and an immediate never depend on an in-flight load.
    assign use1 = (fetch.id_src1_reg != reg_index_t'(PC_REG));
    assign use2 = !fetch.id_src2_is_imm && (fetch.id_src2_reg != reg_index_t'(PC_REG));

    assign load_use = fetch.id_valid && ex_is_load &&
                      ((use1 && ex_match1) || (use2 && ex_match2));

    assign rb_id = rollback_valid && (rollback_strand == fetch.id_strand);
    assign rb_ds = rollback_valid && (rollback_strand == fetch.ds_strand);

    assign fetch.id_stall = !reset && !rb_id && (downstream_stall || load_use);

    always_comb begin
        state_nxt = state_q;
        if (rollback_valid)        state_nxt = ST_RUN;
        else if (downstream_stall) state_nxt = state_q;
        else if (load_use)         state_nxt = ST_LOAD_WAIT;
        else                       state_nxt = ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch.ds_valid    <= 1'b0;
            fetch.ds_strand   <= '0;
            fetch.ds_alu_op   <= '0;
            fetch.ds_operand1 <= '0;
            fetch.ds_operand2 <= '0;
            fetch.ds_dest_reg <= '0;
            fetch.ds_has_dest <= 1'b0;
            fetch.ds_is_load  <= 1'b0;
        end else if (downstream_stall) begin
            if (rb_ds) fetch.ds_valid <= 1'b0;
        end else begin
            fetch.ds_valid    <= fetch.id_valid && !load_use && !rb_id;
            fetch.ds_strand   <= fetch.id_strand;
            fetch.ds_alu_op   <= fetch.id_alu_op;
            fetch.ds_operand1 <= src1_value;
            fetch.ds_operand2 <= operand2;
            fetch.ds_dest_reg <= fetch.id_dest_reg;
            fetch.ds_has_dest <= fetch.id_has_dest;
            fetch.ds_is_load  <= fetch.id_is_load;
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: bypass priority vector table plus
// hand sequences for reset, load-use bubble, downstream stall and rollback.
module tb_operand_fetch_stage;
    import operand_fetch_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    word_t rf_src1_value, rf_src2_value;
    logic ex_valid, ex_has_dest, ex_is_load;
    strand_t ex_strand;
    reg_index_t ex_dest_reg;
    word_t ex_result;
    logic ma_valid, ma_has_dest;
    strand_t ma_strand;
    reg_index_t ma_dest_reg;
    word_t ma_result;
    logic wb_enable;
    strand_t wb_strand;
    reg_index_t wb_reg;
    word_t wb_value;
    logic rollback_valid;
    strand_t rollback_strand;
    logic downstream_stall;

    int checks = 0;
    int errors = 0;

    operand_fetch_stage_if bus ();

    operand_fetch_stage dut (
        .clk(clk), .reset(reset), .fetch(bus),
        .rf_src1_value(rf_src1_value), .rf_src2_value(rf_src2_value),
        .ex_valid(ex_valid), .ex_has_dest(ex_has_dest), .ex_is_load(ex_is_load),
        .ex_strand(ex_strand), .ex_dest_reg(ex_dest_reg), .ex_result(ex_result),
        .ma_valid(ma_valid), .ma_has_dest(ma_has_dest), .ma_strand(ma_strand),
        .ma_dest_reg(ma_dest_reg), .ma_result(ma_result),
        .wb_enable(wb_enable), .wb_strand(wb_strand), .wb_reg(wb_reg), .wb_value(wb_value),
        .rollback_valid(rollback_valid), .rollback_strand(rollback_strand),
        .downstream_stall(downstream_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  s1, s2;
        logic        imm;
        logic        exv, exhd, exld;
        logic [1:0]  exs;
        logic [4:0]  exd;
        logic        mav;
        logic [1:0]  mas;
        logic [4:0]  mad;
        logic        wbe;
        logic [1:0]  wbs;
        logic [4:0]  wbr;
        logic [31:0] e1, e2;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.id_valid = 1'b1;     bus.id_strand = 2'd1;    bus.id_pc = 32'h1000;
        bus.id_alu_op = 6'd1;    bus.id_src1_reg = 5'd3;  bus.id_src2_reg = 5'd4;
        bus.id_src2_is_imm = 1'b0; bus.id_immediate = 32'h40;
        bus.id_dest_reg = 5'd7;  bus.id_has_dest = 1'b1;  bus.id_is_load = 1'b0;
        rf_src1_value = 32'd5;   rf_src2_value = 32'd7;
        ex_valid = 1'b0; ex_has_dest = 1'b1; ex_is_load = 1'b0; ex_strand = 2'd1;
        ex_dest_reg = 5'd0; ex_result = 32'h11;
        ma_valid = 1'b0; ma_has_dest = 1'b1; ma_strand = 2'd1; ma_dest_reg = 5'd0; ma_result = 32'h22;
        wb_enable = 1'b0; wb_strand = 2'd1; wb_reg = 5'd0; wb_value = 32'h33;
        rollback_valid = 1'b0; rollback_strand = 2'd0; downstream_stall = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            s1    s2   imm exv exhd exld exs  exd   mav mas  mad   wbe wbs  wbr   e1        e2
        vecs[0] = '{5'd3, 5'd4, 0, 0, 1, 0, 2'd1, 5'd0,  0, 2'd1, 5'd0,  0, 2'd1, 5'd0,  32'd5,    32'd7};
        vecs[1] = '{5'd3, 5'd4, 0, 1, 1, 0, 2'd1, 5'd3,  1, 2'd1, 5'd3,  1, 2'd1, 5'd3,  32'h11,   32'd7};
        vecs[2] = '{5'd3, 5'd4, 0, 0, 1, 0, 2'd1, 5'd3,  1, 2'd1, 5'd3,  1, 2'd1, 5'd3,  32'h22,   32'd7};
        vecs[3] = '{5'd3, 5'd4, 0, 0, 1, 0, 2'd1, 5'd3,  0, 2'd1, 5'd3,  1, 2'd1, 5'd3,  32'h33,   32'd7};
        vecs[4] = '{5'd3, 5'd4, 0, 1, 1, 1, 2'd2, 5'd4,  0, 2'd1, 5'd0,  0, 2'd1, 5'd0,  32'd5,    32'd7};
        vecs[5] = '{5'd3, 5'd4, 1, 1, 1, 1, 2'd1, 5'd4,  0, 2'd1, 5'd0,  0, 2'd1, 5'd0,  32'd5,    32'h40};
        vecs[6] = '{5'd31,5'd4, 0, 1, 1, 0, 2'd1, 5'd31, 0, 2'd1, 5'd0,  0, 2'd1, 5'd0,  32'h1000, 32'd7};
        vecs[7] = '{5'd3, 5'd4, 0, 1, 0, 0, 2'd1, 5'd4,  1, 2'd0, 5'd4,  0, 2'd1, 5'd0,  32'd5,    32'd7};
        vecs[8] = '{5'd3, 5'd4, 0, 0, 1, 0, 2'd1, 5'd0,  1, 2'd1, 5'd3,  1, 2'd1, 5'd4,  32'h22,   32'h33};

        idle_inputs();
        reset = 1'b1;
        #1;
        chk("reset_id_stall", 32'(bus.id_stall), 32'd0);
        step();
        step();
        chk("reset_ds_valid", 32'(bus.ds_valid), 32'd0);
        chk("reset_ds_operand1", bus.ds_operand1, 32'd0);
        chk("reset_ds_alu_op", 32'(bus.ds_alu_op), 32'd0);
        reset = 1'b0;

        // Bypass priority and hazard-free vectors.
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            bus.id_alu_op = 6'(i + 2);
            bus.id_src1_reg = vecs[i].s1;  bus.id_src2_reg = vecs[i].s2;
            bus.id_src2_is_imm = vecs[i].imm;
            ex_valid = vecs[i].exv; ex_has_dest = vecs[i].exhd; ex_is_load = vecs[i].exld;
            ex_strand = vecs[i].exs; ex_dest_reg = vecs[i].exd;
            ma_valid = vecs[i].mav; ma_strand = vecs[i].mas; ma_dest_reg = vecs[i].mad;
            wb_enable = vecs[i].wbe; wb_strand = vecs[i].wbs; wb_reg = vecs[i].wbr;
            #1;
            chk($sformatf("vec%0d_id_stall", i), 32'(bus.id_stall), 32'd0);
            step();
            chk($sformatf("vec%0d_ds_valid", i), 32'(bus.ds_valid), 32'd1);
            chk($sformatf("vec%0d_operand1", i), bus.ds_operand1, vecs[i].e1);
            chk($sformatf("vec%0d_operand2", i), bus.ds_operand2, vecs[i].e2);
            chk($sformatf("vec%0d_alu_op", i), 32'(bus.ds_alu_op), 32'(i + 2));
        end

        // Load-use: one bubble, then operand from ma.
        idle_inputs();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_dest_reg = 5'd4;
        #1;
        chk("lu_c0_id_stall", 32'(bus.id_stall), 32'd1);
        step();
        chk("lu_c0_ds_valid", 32'(bus.ds_valid), 32'd0);
        ex_valid = 1'b0; ex_is_load = 1'b0;
        ma_valid = 1'b1; ma_dest_reg = 5'd4; ma_result = 32'hDEAD;
        #1;
        chk("lu_c1_id_stall", 32'(bus.id_stall), 32'd0);
        step();
        chk("lu_c1_ds_valid", 32'(bus.ds_valid), 32'd1);
        chk("lu_c1_operand2", bus.ds_operand2, 32'hDEAD);
        chk("lu_c1_operand1", bus.ds_operand1, 32'd5);

        // Downstream stall holds a valid output; rollback on ds strand clears it.
        idle_inputs();
        bus.id_alu_op = 6'd9;
        step();
        chk("ds_pre_valid", 32'(bus.ds_valid), 32'd1);
        downstream_stall = 1'b1;
        bus.id_strand = 2'd2; bus.id_alu_op = 6'd20; rf_src1_value = 32'd99;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_id_stall", c), 32'(bus.id_stall), 32'd1);
            step();
            chk($sformatf("stall%0d_ds_valid", c), 32'(bus.ds_valid), 32'd1);
            chk($sformatf("stall%0d_operand1", c), bus.ds_operand1, 32'd5);
            chk($sformatf("stall%0d_alu_op", c), 32'(bus.ds_alu_op), 32'd9);
        end
        rollback_valid = 1'b1; rollback_strand = 2'd1;
        #1;
        chk("rb_ds_id_stall", 32'(bus.id_stall), 32'd1);
        step();
        chk("rb_ds_ds_valid", 32'(bus.ds_valid), 32'd0);
        chk("rb_ds_alu_op_held", 32'(bus.ds_alu_op), 32'd9);

        // Rollback on the incoming strand drops it without stalling decode.
        idle_inputs();
        downstream_stall = 1'b1;
        rollback_valid = 1'b1; rollback_strand = 2'd1;
        #1;
        chk("rb_id_id_stall", 32'(bus.id_stall), 32'd0);
        downstream_stall = 1'b0;
        step();
        chk("rb_id_ds_valid", 32'(bus.ds_valid), 32'd0);

        // Rollback cancels a pending LOAD_WAIT; the next load-use stalls again.
        idle_inputs();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_dest_reg = 5'd3;
        step();
        rollback_valid = 1'b1; rollback_strand = 2'd3;
        step();
        rollback_valid = 1'b0;
        #1;
        chk("rb_fsm_id_stall", 32'(bus.id_stall), 32'd1);
        step();
        chk("rb_fsm_ds_valid", 32'(bus.ds_valid), 32'd0);

        // id_valid low registers a bubble.
        idle_inputs();
        bus.id_valid = 1'b0;
        step();
        chk("bubble_ds_valid", 32'(bus.ds_valid), 32'd0);

        // Reset during a downstream stall clears the held output.
        idle_inputs();
        step();
        chk("mid_pre_valid", 32'(bus.ds_valid), 32'd1);
        downstream_stall = 1'b1;
        reset = 1'b1;
        #1;
        chk("mid_reset_id_stall", 32'(bus.id_stall), 32'd0);
        step();
        chk("mid_reset_ds_valid", 32'(bus.ds_valid), 32'd0);
        chk("mid_reset_operand1", bus.ds_operand1, 32'd0);
        reset = 1'b0;
        downstream_stall = 1'b0;
        step();
        chk("post_reset_ds_valid", 32'(bus.ds_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
